// File: rtl/param_serial_alu_if.sv
// ---------------------------------------------------------------------------
// param_serial_alu_if
// Bundles the load / opcode / execute / readout signals of param_serial_alu.
//   master : drives A, B, ld, opLd, op_in, exe, res_rd; observes the outputs
//   slave  : the ALU side; drives res, res_valid, opnd_full, err, flags
// Parameters: BW = load beat width, OW = result read-port width.
// ---------------------------------------------------------------------------
interface param_serial_alu_if #(
    parameter int BW = 8,
    parameter int OW = 16
);
    logic [BW-1:0] A;
    logic [BW-1:0] B;
    logic          ld;
    logic          opLd;
    logic [5:0]    op_in;
    logic          exe;
    logic          res_rd;
    logic [OW-1:0] res;
    logic          res_valid;
    logic          opnd_full;
    logic          err;
    logic [3:0]    flags;

    modport master (
        output A, B, ld, opLd, op_in, exe, res_rd,
        input  res, res_valid, opnd_full, err, flags
    );

    modport slave (
        input  A, B, ld, opLd, op_in, exe, res_rd,
        output res, res_valid, opnd_full, err, flags
    );
endinterface

// File: rtl/param_serial_alu.sv
// ---------------------------------------------------------------------------
// param_serial_alu
// Serially loaded ALU: operands arrive as NB beats of BW bits (LSB beat
// first), an opcode is latched separately, exe computes a DW-bit result in
// one cycle, and the result is read out OW bits at a time.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - param_serial_alu_if.slave (load beats, opcode, exe, readout,
//          status outputs res/res_valid/opnd_full/err/flags)
// flags = {neg, ovf, carry, zero} of the last accepted exe.
// ---------------------------------------------------------------------------
module param_serial_alu #(
    parameter int DW = 32,
    parameter int BW = 8,
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    param_serial_alu_if.slave    bus
);
    localparam int NB = DW / BW;
    localparam int NR = DW / OW;
    localparam int SW = $clog2(DW);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW = (NR > 1) ? $clog2(NR) : 1;

    logic [CW-1:0] ld_cnt_r;
    logic [DW-1:0] opa_r;
    logic [DW-1:0] opb_r;
    logic [5:0]    op_r;
    logic [DW-1:0] result_r;
    logic [3:0]    flags_r;
    logic [RW-1:0] rd_idx_r;
    logic [OW-1:0] res_r;
    logic          res_valid_r;
    logic          opnd_full_r;
    logic          err_r;

    logic          op_valid_s;
    logic          is_imm_s;
    logic [5:0]    base_op_s;
    logic [DW-1:0] eff_b_s;
    logic [SW-1:0] shamt_s;
    logic [DW:0]   sum_s;
    logic [DW:0]   diff_s;
    logic [DW-1:0] alu_res_s;
    logic          carry_s;
    logic          ovf_s;
    logic          accept_s;
    logic          ld_first_s;
    logic          ld_last_s;
    logic [RW-1:0] rd_next_s;

    // Opcode decode: 9..17 are immediate variants of 0..8, 18+ are invalid.
    always_comb begin
        op_valid_s = (op_r < 6'd18);
        is_imm_s   = (op_r >= 6'd9);
        if (is_imm_s) begin
            base_op_s = op_r - 6'd9;
        end else begin
            base_op_s = op_r;
        end
    end

    // Effective B operand: immediate forms sign-extend the low beat of opB.
    always_comb begin
        if (is_imm_s) begin
            eff_b_s = DW'($signed(opb_r[BW-1:0]));
        end else begin
            eff_b_s = opb_r;
        end
        shamt_s = eff_b_s[SW-1:0];
    end

    // ALU datapath and carry/overflow generation.
    always_comb begin
        sum_s     = {1'b0, opa_r} + {1'b0, eff_b_s};
        // Top bit of the widened difference is the unsigned borrow (opA < B).
        diff_s    = {1'b0, opa_r} - {1'b0, eff_b_s};
        alu_res_s = {DW{1'b0}};
        carry_s   = 1'b0;
        ovf_s     = 1'b0;
        case (base_op_s)
            6'd0: begin
                alu_res_s = sum_s[DW-1:0];
                carry_s   = sum_s[DW];
                ovf_s     = (opa_r[DW-1] == eff_b_s[DW-1]) &&
                            (sum_s[DW-1] != opa_r[DW-1]);
            end
            6'd1: begin
                alu_res_s = diff_s[DW-1:0];
                carry_s   = diff_s[DW];
                ovf_s     = (opa_r[DW-1] != eff_b_s[DW-1]) &&
                            (diff_s[DW-1] != opa_r[DW-1]);
            end
            6'd2:    alu_res_s = opa_r & eff_b_s;
            6'd3:    alu_res_s = opa_r | eff_b_s;
            6'd4:    alu_res_s = opa_r ^ eff_b_s;
            6'd5:    alu_res_s = ~opa_r;
            6'd6:    alu_res_s = opa_r << shamt_s;
            6'd7:    alu_res_s = $signed(opa_r) >>> shamt_s;
            6'd8:    alu_res_s = opa_r >> shamt_s;
            default: alu_res_s = {DW{1'b0}};
        endcase
    end

    // Control strobes shared by the register blocks below.
    always_comb begin
        accept_s   = bus.exe && opnd_full_r && op_valid_s;
        ld_first_s = bus.ld && (ld_cnt_r == {CW{1'b0}});
        ld_last_s  = bus.ld && (ld_cnt_r == CW'(NB - 1));
        if (rd_idx_r == RW'(NR - 1)) begin
            rd_next_s = {RW{1'b0}};
        end else begin
            rd_next_s = rd_idx_r + 1'b1;
        end
    end

    // Operand beat loader; exe on the same edge still sees the old operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt_r <= {CW{1'b0}};
            opa_r    <= {DW{1'b0}};
            opb_r    <= {DW{1'b0}};
        end else if (bus.ld) begin
            opa_r[ld_cnt_r*BW +: BW] <= bus.A;
            opb_r[ld_cnt_r*BW +: BW] <= bus.B;
            if (ld_last_s) begin
                ld_cnt_r <= {CW{1'b0}};
            end else begin
                ld_cnt_r <= ld_cnt_r + 1'b1;
            end
        end
    end

    // Opcode register; reset value is ADD.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r <= 6'd0;
        end else if (bus.opLd) begin
            op_r <= bus.op_in;
        end
    end

    // Result capture and chunked readout; an accepted exe restarts at chunk 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {DW{1'b0}};
            flags_r  <= 4'd0;
            rd_idx_r <= {RW{1'b0}};
            res_r    <= {OW{1'b0}};
        end else if (accept_s) begin
            result_r <= alu_res_s;
            flags_r  <= {alu_res_s[DW-1], ovf_s, carry_s, (alu_res_s == {DW{1'b0}})};
            rd_idx_r <= {RW{1'b0}};
            res_r    <= alu_res_s[OW-1:0];
        end else if (bus.res_rd && res_valid_r) begin
            rd_idx_r <= rd_next_s;
            res_r    <= result_r[rd_next_s*OW +: OW];
        end
    end

    // Status bits; a first-beat load invalidates the held result even if exe
    // is accepted on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            opnd_full_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            err_r <= bus.exe && !accept_s;
            if (ld_last_s) begin
                opnd_full_r <= 1'b1;
            end else if (ld_first_s) begin
                opnd_full_r <= 1'b0;
            end
            if (ld_first_s) begin
                res_valid_r <= 1'b0;
            end else if (accept_s) begin
                res_valid_r <= 1'b1;
            end
        end
    end

    assign bus.res       = res_r;
    assign bus.res_valid = res_valid_r;
    assign bus.opnd_full = opnd_full_r;
    assign bus.err       = err_r;
    assign bus.flags     = flags_r;

endmodule

// File: tb/tb_param_serial_alu.sv
// ---------------------------------------------------------------------------
// tb_param_serial_alu
// Self-checking bench for param_serial_alu (DW=32, BW=8, OW=16). A
// behavioural model tracks whole 32-bit operands and computes results and
// flags with plain integer arithmetic; every cycle the DUT outputs are
// compared to it. Directed scenarios also check fixed known answers.
// ---------------------------------------------------------------------------
module tb_param_serial_alu;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    param_serial_alu_if #(.BW(8), .OW(16)) bus ();

    param_serial_alu #(.DW(32), .BW(8), .OW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    bit [31:0] m_a, m_b, m_result;
    bit [5:0]  m_op;
    bit [3:0]  m_flags;
    int        m_cnt, m_idx;
    bit        m_full, m_valid, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void ref_alu(input bit [5:0] op, input bit [31:0] a, input bit [31:0] b,
                                    output bit [31:0] r, output bit [3:0] f);
        int unsigned base;
        bit          imm, c, v;
        bit signed [7:0] lo;
        bit [31:0]   eb;
        int          ia, ib, t;
        longint      s, u;
        base = op % 9;
        imm  = (op >= 9);
        lo   = b[7:0];
        if (imm) begin
            t  = lo;
            eb = t;
        end else begin
            eb = b;
        end
        ia = a;
        ib = eb;
        c  = 1'b0;
        v  = 1'b0;
        case (base)
            0: begin
                u = longint'(a) + longint'(eb);
                r = u[31:0];
                c = u[32];
                s = longint'(ia) + longint'(ib);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1: begin
                r = a - eb;
                c = (a < eb);
                s = longint'(ia) - longint'(ib);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2: r = a & eb;
            3: r = a | eb;
            4: r = a ^ eb;
            5: r = ~a;
            6: r = a << eb[4:0];
            7: r = ia >>> eb[4:0];
            default: r = a >> eb[4:0];
        endcase
        f = {r[31], v, c, (r == 32'd0)};
    endfunction

    // Advance the model by one clock using the inputs currently applied,
    // clock the DUT, then compare all outputs.
    task automatic cycle();
        bit [31:0] r;
        bit [3:0]  f;
        bit        acc;
        if (rst) begin
            m_a = 0; m_b = 0; m_result = 0; m_op = 0; m_flags = 0;
            m_cnt = 0; m_idx = 0; m_full = 0; m_valid = 0; m_err = 0;
        end else begin
            acc   = bus.exe && m_full && (m_op < 18);
            m_err = bus.exe && !acc;
            if (acc) begin
                ref_alu(m_op, m_a, m_b, r, f);
                m_result = r;
                m_flags  = f;
                m_valid  = 1;
                m_idx    = 0;
            end else if (bus.res_rd && m_valid) begin
                m_idx = (m_idx + 1) % 2;
            end
            if (bus.ld) begin
                if (m_cnt == 0) begin
                    m_full  = 0;
                    m_valid = 0;
                end
                m_a[m_cnt*8 +: 8] = bus.A;
                m_b[m_cnt*8 +: 8] = bus.B;
                if (m_cnt == 3) m_full = 1;
                m_cnt = (m_cnt + 1) % 4;
            end
            if (bus.opLd) m_op = bus.op_in;
        end
        @(posedge clk);
        #1;
        chk("res",       bus.res,       (m_result >> (m_idx * 16)) & 32'hFFFF);
        chk("res_valid", bus.res_valid, m_valid);
        chk("opnd_full", bus.opnd_full, m_full);
        chk("err",       bus.err,       m_err);
        chk("flags",     bus.flags,     m_flags);
    endtask

    task automatic drive(input bit ld, input bit [7:0] a, input bit [7:0] b, input bit opld,
                         input bit [5:0] op, input bit exe, input bit rd, input bit r);
        bus.ld = ld; bus.A = a; bus.B = b; bus.opLd = opld; bus.op_in = op;
        bus.exe = exe; bus.res_rd = rd; rst = r;
        cycle();
        bus.ld = 0; bus.A = 0; bus.B = 0; bus.opLd = 0; bus.op_in = 0;
        bus.exe = 0; bus.res_rd = 0; rst = 0;
    endtask

    task automatic beat(input bit [7:0] a, input bit [7:0] b);
        drive(1, a, b, 0, 0, 0, 0, 0);
    endtask

    task automatic load4(input bit [31:0] a, input bit [31:0] b);
        for (int i = 0; i < 4; i++) beat(a[i*8 +: 8], b[i*8 +: 8]);
    endtask

    task automatic setop(input bit [5:0] op);
        drive(0, 0, 0, 1, op, 0, 0, 0);
    endtask

    task automatic do_exe();
        drive(0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic do_rd();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic do_rst();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.ld = 0; bus.A = 0; bus.B = 0; bus.opLd = 0; bus.op_in = 0;
        bus.exe = 0; bus.res_rd = 0;

        // reset state
        do_rst();
        chk("rst_res", bus.res, 32'h0);
        chk("rst_valid", bus.res_valid, 32'h0);

        // basic add and readout wrap
        load4(32'h12345678, 32'h00000001);
        setop(6'd0);
        do_exe();
        chk("add_lo", bus.res, 32'h5679);
        chk("add_valid", bus.res_valid, 32'h1);
        chk("add_flags", bus.flags, 32'h0);
        do_rd();
        chk("add_hi", bus.res, 32'h1234);
        do_rd();
        chk("add_wrap", bus.res, 32'h5679);

        // SUB borrow
        load4(32'h0, 32'h1);
        setop(6'd1);
        do_exe();
        chk("sub_lo", bus.res, 32'hFFFF);
        chk("sub_flags", bus.flags, 32'hA);

        // signed overflow on ADD
        load4(32'h7FFFFFFF, 32'h1);
        setop(6'd0);
        do_exe();
        do_rd();
        chk("ovf_hi", bus.res, 32'h8000);
        chk("ovf_flags", bus.flags, 32'hC);

        // ADDI with sign-extended 0xFF
        load4(32'h5, 32'hFF);
        setop(6'd9);
        do_exe();
        chk("addi_lo", bus.res, 32'h4);
        chk("addi_flags", bus.flags, 32'h2);

        // shifts
        load4(32'h80000000, 32'h4);
        setop(6'd7);
        do_exe();
        do_rd();
        chk("sra_hi", bus.res, 32'hF800);
        setop(6'd8);
        do_exe();
        do_rd();
        chk("srl_hi", bus.res, 32'h0800);
        load4(32'h1, 32'd31);
        setop(6'd6);
        do_exe();
        do_rd();
        chk("sla_hi", bus.res, 32'h8000);

        // exe rejected: partial load, then invalid opcode
        do_rst();
        beat(8'h11, 8'h22);
        beat(8'h33, 8'h44);
        do_exe();
        chk("part_err", bus.err, 32'h1);
        chk("part_valid", bus.res_valid, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("err_pulse", bus.err, 32'h0);
        beat(8'h55, 8'h66);
        beat(8'h77, 8'h88);
        setop(6'd20);
        do_exe();
        chk("inv_err", bus.err, 32'h1);

        // reset mid-load, then fresh operands
        beat(8'hEE, 8'hEE);
        beat(8'hEE, 8'hEE);
        do_rst();
        beat(8'hD4, 8'h00);
        chk("fresh1", bus.opnd_full, 32'h0);
        beat(8'hC3, 8'h00);
        beat(8'hB2, 8'h00);
        chk("fresh3", bus.opnd_full, 32'h0);
        beat(8'hA1, 8'h00);
        chk("fresh4", bus.opnd_full, 32'h1);
        setop(6'd3);
        do_exe();
        chk("fresh_lo", bus.res, 32'hC3D4);
        do_rd();
        chk("fresh_hi", bus.res, 32'hA1B2);

        // randomized traffic, model-checked every cycle
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 99) < 40, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 99) < 10,
                  ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 17)),
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 30,
                  $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/param_serial_alu.md
PARAM_SERIAL_ALU -- requirements
Module: param_serial_alu

Interface
REQ-001 SHALL have parameter DW, default 32, operand/result width in bits.
REQ-002 SHALL have parameter BW, default 8, load-bus beat width; DW SHALL be a multiple of BW.
REQ-003 SHALL have parameter OW, default 16, result read-port width; DW SHALL be a multiple of OW.
REQ-004 Derived constants: NB = DW/BW load beats; NR = DW/OW read chunks; SW = log2(DW) shift-amount bits.
REQ-005 clk  in  1  single clock; all state changes on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 A  in  BW  operand A load beat.
REQ-008 B  in  BW  operand B load beat.
REQ-009 ld  in  1  load one beat of A and B.
REQ-010 opLd  in  1  latch opcode from op_in.
REQ-011 op_in  in  6  opcode.
REQ-012 exe  in  1  execute request.
REQ-013 res_rd  in  1  advance result read chunk.
REQ-014 res  out  OW  registered result chunk.
REQ-015 res_valid  out  1  result held and readable.
REQ-016 opnd_full  out  1  all NB beats loaded.
REQ-017 err  out  1  one-cycle pulse, rejected exe.
REQ-018 flags  out  4  {neg, ovf, carry, zero} of last accepted exe.

Function
REQ-019 Beat counter ld_cnt (0..NB-1): ld writes A/B into bits [ld_cnt*BW +: BW] of opA/opB, LSB beat first; ld_cnt wraps NB-1 -> 0.
REQ-020 A ld with ld_cnt=0 SHALL clear opnd_full and res_valid; a ld with ld_cnt=NB-1 SHALL set opnd_full.
REQ-021 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(~opA), 6 SLA, 7 SRA, 8 SRL; 9..17 are immediate forms of 0..8 respectively; 18..63 invalid.
REQ-022 Immediate forms SHALL use effective B = sign-extension of opB[BW-1:0] to DW; register forms use opB.
REQ-023 Shifts SHALL use effective B[SW-1:0]: SLA logical left; SRA arithmetic right (sign-fill); SRL logical right (zero-fill).
REQ-024 exe accepted only if opnd_full=1 and latched opcode valid; otherwise err=1 for the following cycle, with result, flags and res_valid unchanged.
REQ-025 Accepted exe: 1-cycle latency; at next edge the DW-bit result is registered, res_valid=1, read index rd_idx=0, res=result[OW-1:0].
REQ-026 res_rd with res_valid=1 SHALL increment rd_idx mod NR and present result[rd_idx*OW +: OW] from the next edge; res_rd with res_valid=0 SHALL be ignored.
REQ-027 zero = (result==0); neg = result[DW-1]; carry = carry-out (ADD) or borrow, opA<B unsigned (SUB); ovf = signed overflow (ADD/SUB); carry and ovf = 0 for all other ops.
REQ-028 Arithmetic is modulo 2^DW; no saturation.
REQ-029 Same-edge exe and ld: exe uses operands before this edge's write; ld write also applied; a ld with ld_cnt=0 wins over res_valid set (res_valid=0).
REQ-030 Same-edge exe and opLd: exe uses previously latched opcode.
REQ-031 Same-edge exe and res_rd: exe wins; rd_idx=0.
REQ-032 Operands and result SHALL persist; repeated exe re-executes on held operands.

Reset
REQ-033 rst SHALL set res=0, flags=0, res_valid=0, opnd_full=0, err=0, ld_cnt=0, rd_idx=0, opcode=ADD, opA=opB=0.
REQ-034 rst SHALL override all simultaneous inputs, including mid-load and mid-readout.

Verification (DW=32, BW=8, OW=16)
REQ-035 Beats A=78,56,34,12 / B=01,00,00,00, opLd 0, exe -> res=0x5679, res_valid=1, flags=0000; res_rd -> 0x1234; res_rd -> 0x5679 (wrap).
REQ-036 A=0, B=1, SUB -> result 0xFFFFFFFF, neg=1, carry=1, ovf=0, zero=0.
REQ-037 A=0x7FFFFFFF, B=1, ADD -> 0x80000000, ovf=1, neg=1; A=0x00000005, B low byte 0xFF, ADDI -> 0x00000004, carry=1.
REQ-038 A=0x80000000, B=4: SRA -> 0xF8000000; SRL -> 0x08000000; SLA on A=1 B=31 -> 0x80000000.
REQ-039 Two beats only then exe -> err pulses one cycle, res_valid=0; opcode 20 latched after full load, exe -> err pulse.
REQ-040 rst after two beats, then four fresh beats -> opnd_full=1 only after fourth beat, operands equal fresh beats exactly.
